// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the pong engine: the FSM state encoding and a
// parameter legality check used by pong_core at elaboration time.
package pong_pkg;

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    POINT   = 3'd3,
    SERVE   = 3'd4,
    OVER    = 3'd5
  } state_t;

  // The track must be even and at least 4 long so that each player owns
  // half of the display for the score view. The score must fit in half the
  // display, the winning score must be reachable in SW bits, and the
  // initial period must fit the period register and sit at or above the floor.
  function automatic bit params_legal(input int n, input int sw, input int win,
                                      input int init_p, input int min_p,
                                      input int pw);
    return (n >= 4) && ((n % 2) == 0) && (sw >= 1) && (sw <= n / 2) &&
           (win >= 1) && (win <= (1 << sw) - 1) &&
           (min_p >= 1) && (init_p >= min_p) && (init_p < (1 << pw));
  endfunction

endpackage

// File: rtl/pong_step_timer.sv
// pong_step_timer
// Paces the ball: counts step_en ticks and raises move on the tick that
// completes the current period. The period shrinks by one on every return
// (never below MIN_PERIOD) and is restored to INIT_PERIOD on a launch.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load_init   restore period to INIT_PERIOD and clear the tick counter
//   speed_up    shorten the period by one (floored) and clear the tick counter
//   step_en     qualified pacing tick, already gated by the caller
//   move        combinational strobe: the ball advances this cycle
module pong_step_timer #(
  parameter int INIT_PERIOD = 4,
  parameter int MIN_PERIOD  = 1,
  parameter int PW          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_init,
  input  logic speed_up,
  input  logic step_en,
  output logic move
);

  logic [PW-1:0] period;
  logic [PW-1:0] tick_cnt;

  assign move = step_en && (tick_cnt == period - PW'(1));

  // Launch and return both restart counting from zero so the first move
  // after either takes a full period. load_init outranks speed_up although
  // the caller never asserts both together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period   <= PW'(INIT_PERIOD);
      tick_cnt <= '0;
    end else if (load_init) begin
      period   <= PW'(INIT_PERIOD);
      tick_cnt <= '0;
    end else if (speed_up) begin
      period   <= (period > PW'(MIN_PERIOD)) ? period - PW'(1) : PW'(MIN_PERIOD);
      tick_cnt <= '0;
    end else if (step_en) begin
      tick_cnt <= move ? '0 : tick_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pong_core.sv
// pong_core
// Ping-pong game engine: a ball runs along an N-position track between the
// right player (position 0) and the left player (position N-1). Returning
// the ball at your end speeds the rally up; missing it or hitting early
// concedes a point. First to WIN_SCORE ends the match.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   step_en             pacing tick for ball motion
//   hit_r, hit_l        single-cycle player press pulses
//   disp                display vector (ball one-hot, scores or winner)
//   ball_pos            current ball index
//   ball_active         ball in flight
//   score_r, score_l    running scores
//   state_o             encoded FSM state
//   point_r, point_l    one-cycle point award pulses
//   match_over, winner  match finished / winner (1 = right)
module pong_core
  import pong_pkg::*;
#(
  parameter int N           = 8,
  parameter int SW          = 4,
  parameter int WIN_SCORE   = 7,
  parameter int INIT_PERIOD = 4,
  parameter int MIN_PERIOD  = 1,
  parameter int PW          = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_en,
  input  logic                 hit_r,
  input  logic                 hit_l,
  output logic [N-1:0]         disp,
  output logic [$clog2(N)-1:0] ball_pos,
  output logic                 ball_active,
  output logic [SW-1:0]        score_r,
  output logic [SW-1:0]        score_l,
  output logic [2:0]           state_o,
  output logic                 point_r,
  output logic                 point_l,
  output logic                 match_over,
  output logic                 winner
);

  localparam int              POS_W    = $clog2(N);
  localparam int              HALF     = N / 2;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N - 1);
  localparam logic [SW-1:0]   WIN      = SW'(WIN_SCORE);

  if (!params_legal(N, SW, WIN_SCORE, INIT_PERIOD, MIN_PERIOD, PW)) begin : g_illegal_params
    $error("pong_core: illegal parameter set");
  end

  state_t state;
  logic   server;
  logic   at_far_end, recv_hit, speed_up, launch, load_init, timer_step, move;
  logic   award_r, award_l;

  function automatic logic [N-1:0] one_hot(input logic [POS_W-1:0] p);
    return N'(1) << p;
  endfunction

  function automatic logic [N-1:0] score_view(input logic [SW-1:0] r, input logic [SW-1:0] l);
    return {HALF'(l), HALF'(r)};
  endfunction

  function automatic logic [N-1:0] win_view(input logic right_won);
    return right_won ? {{HALF{1'b0}}, {HALF{1'b1}}} : {{HALF{1'b1}}, {HALF{1'b0}}};
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s >= WIN) ? s : s + SW'(1);
  endfunction

  assign state_o     = state;
  assign ball_active = (state == MOVE_UP) || (state == MOVE_DN);
  assign match_over  = (state == OVER);

  // The receiving player is the one the ball travels toward. Their hit is a
  // return only at their own end; anywhere else it is an early fault. A move
  // strobe at the far end means the receiver let the ball through. The step
  // is suppressed in any cycle the receiver hits, so a hit always wins over
  // a coincident move and an early fault never also advances the ball.
  always_comb begin
    at_far_end = (state == MOVE_UP) ? (ball_pos == LAST_POS) : (ball_pos == '0);
    recv_hit   = ((state == MOVE_UP) && hit_l) || ((state == MOVE_DN) && hit_r);
    speed_up   = recv_hit && at_far_end;
    launch     = ((state == IDLE) && (hit_r || hit_l)) ||
                 ((state == SERVE) && ((server && hit_r) || (!server && hit_l)));
    load_init  = launch || ((state == OVER) && (hit_r || hit_l));
    timer_step = step_en && ball_active && !recv_hit;
    award_r    = (state == MOVE_UP) && ((hit_l && !at_far_end) || (move && at_far_end));
    award_l    = (state == MOVE_DN) && ((hit_r && !at_far_end) || (move && at_far_end));
  end

  pong_step_timer #(
    .INIT_PERIOD (INIT_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .PW          (PW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_init (load_init),
    .speed_up  (speed_up),
    .step_en   (timer_step),
    .move      (move)
  );

  // Game FSM. disp is loaded alongside the state change so that it is a
  // register and always agrees with state_o in the same cycle. Entering
  // POINT updates the score and fires the point pulse together; POINT then
  // decides between SERVE and OVER from the freshly updated score.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ball_pos <= '0;
      score_r  <= '0;
      score_l  <= '0;
      server   <= 1'b0;
      winner   <= 1'b0;
      point_r  <= 1'b0;
      point_l  <= 1'b0;
      disp     <= N'(1);
    end else begin
      point_r <= 1'b0;
      point_l <= 1'b0;
      if (award_r) begin
        state   <= POINT;
        point_r <= 1'b1;
        score_r <= sat_inc(score_r);
        server  <= 1'b1;
        disp    <= score_view(sat_inc(score_r), score_l);
      end else if (award_l) begin
        state   <= POINT;
        point_l <= 1'b1;
        score_l <= sat_inc(score_l);
        server  <= 1'b0;
        disp    <= score_view(score_r, sat_inc(score_l));
      end else begin
        unique case (state)
          IDLE, SERVE: begin
            if (launch && hit_r && (state == IDLE || server)) begin
              state    <= MOVE_UP;
              ball_pos <= '0;
              disp     <= one_hot('0);
            end else if (launch) begin
              state    <= MOVE_DN;
              ball_pos <= LAST_POS;
              disp     <= one_hot(LAST_POS);
            end
          end
          MOVE_UP: begin
            if (speed_up) begin
              state <= MOVE_DN;
            end else if (move) begin
              ball_pos <= ball_pos + POS_W'(1);
              disp     <= one_hot(ball_pos + POS_W'(1));
            end
          end
          MOVE_DN: begin
            if (speed_up) begin
              state <= MOVE_UP;
            end else if (move) begin
              ball_pos <= ball_pos - POS_W'(1);
              disp     <= one_hot(ball_pos - POS_W'(1));
            end
          end
          POINT: begin
            if (score_r == WIN || score_l == WIN) begin
              state  <= OVER;
              winner <= (score_r == WIN);
              disp   <= win_view(score_r == WIN);
            end else begin
              state <= SERVE;
            end
          end
          OVER: begin
            if (hit_r || hit_l) begin
              state    <= IDLE;
              score_r  <= '0;
              score_l  <= '0;
              server   <= 1'b0;
              ball_pos <= '0;
              disp     <= N'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_core.sv
// tb_pong_core
// Self-checking bench for pong_core (N=8, WIN_SCORE=3, INIT_PERIOD=4,
// MIN_PERIOD=1). A game-level model tracks the ball as a position plus a
// direction and predicts every output after every clock edge.
module tb_pong_core;

  localparam int N     = 8;
  localparam int SW    = 4;
  localparam int WINS  = 3;
  localparam int INITP = 4;
  localparam int MINP  = 1;
  localparam int PW    = 4;
  localparam int HALF  = N / 2;

  localparam int P_IDLE = 0, P_UP = 1, P_DN = 2, P_POINT = 3, P_SERVE = 4, P_OVER = 5;

  logic          clk = 1'b0;
  logic          rst_n, step_en, hit_r, hit_l;
  logic [N-1:0]  disp;
  logic [2:0]    ball_pos;
  logic          ball_active, point_r, point_l, match_over, winner;
  logic [SW-1:0] score_r, score_l;
  logic [2:0]    state_o;

  int testsRun  = 0;
  int failCount = 0;

  // Model of the game
  int mPhase, mPos, mDir, mPeriod, mTicks, mScoreR, mScoreL;
  bit mServerRight, mWinnerRight, mLastRight, mPtR, mPtL;

  pong_core #(
    .N(N), .SW(SW), .WIN_SCORE(WINS), .INIT_PERIOD(INITP), .MIN_PERIOD(MINP), .PW(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .hit_r(hit_r), .hit_l(hit_l),
    .disp(disp), .ball_pos(ball_pos), .ball_active(ball_active),
    .score_r(score_r), .score_l(score_l), .state_o(state_o),
    .point_r(point_r), .point_l(point_l), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic launch(input int dir);
    mDir    = dir;
    mPos    = (dir > 0) ? 0 : N - 1;
    mPhase  = (dir > 0) ? P_UP : P_DN;
    mPeriod = INITP;
    mTicks  = 0;
  endtask

  task automatic award(input bit rightWins);
    mPhase     = P_POINT;
    mLastRight = rightWins;
    if (rightWins) begin mScoreR++; mPtR = 1; end
    else begin mScoreL++; mPtL = 1; end
  endtask

  // One clock edge of game rules.
  task automatic modelStep(input bit rn, input bit hr, input bit hl, input bit se);
    bit recvHit;
    int farEnd;
    mPtR = 0;
    mPtL = 0;
    if (!rn) begin
      mPhase = P_IDLE; mPos = 0; mScoreR = 0; mScoreL = 0;
      mPeriod = INITP; mTicks = 0; mWinnerRight = 0; mServerRight = 0;
      return;
    end
    case (mPhase)
      P_IDLE: if (hr) launch(1); else if (hl) launch(-1);
      P_UP, P_DN: begin
        recvHit = (mDir > 0) ? hl : hr;
        farEnd  = (mDir > 0) ? N - 1 : 0;
        if (recvHit) begin
          if (mPos == farEnd) begin
            mDir    = -mDir;
            mPhase  = (mDir > 0) ? P_UP : P_DN;
            mPeriod = (mPeriod - 1 > MINP) ? mPeriod - 1 : MINP;
            mTicks  = 0;
          end else award(mDir > 0);
        end else if (se) begin
          if (mTicks == mPeriod - 1) begin
            mTicks = 0;
            if (mPos == farEnd) award(mDir > 0);
            else mPos += mDir;
          end else mTicks++;
        end
      end
      P_POINT: begin
        mServerRight = mLastRight;
        if (mScoreR == WINS || mScoreL == WINS) begin
          mPhase = P_OVER;
          mWinnerRight = mLastRight;
        end else mPhase = P_SERVE;
      end
      P_SERVE: if (mServerRight && hr) launch(1); else if (!mServerRight && hl) launch(-1);
      P_OVER: if (hr || hl) begin
        mPhase = P_IDLE; mScoreR = 0; mScoreL = 0; mPeriod = INITP; mTicks = 0; mPos = 0;
      end
      default: mPhase = P_IDLE;
    endcase
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] expDisp, lowMask;
    lowMask = (N'(1) << HALF) - N'(1);
    case (mPhase)
      P_UP, P_DN:       expDisp = N'(1) << mPos;
      P_POINT, P_SERVE: expDisp = (N'(mScoreL) << HALF) | N'(mScoreR);
      P_OVER:           expDisp = mWinnerRight ? lowMask : (lowMask << HALF);
      default:          expDisp = N'(1);
    endcase
    checkVal("state_o", 32'(state_o), 32'(mPhase));
    checkVal("disp", 32'(disp), 32'(expDisp));
    checkVal("ball_active", 32'(ball_active), 32'(mPhase == P_UP || mPhase == P_DN));
    checkVal("score_r", 32'(score_r), 32'(mScoreR));
    checkVal("score_l", 32'(score_l), 32'(mScoreL));
    checkVal("point_r", 32'(point_r), 32'(mPtR));
    checkVal("point_l", 32'(point_l), 32'(mPtL));
    checkVal("match_over", 32'(match_over), 32'(mPhase == P_OVER));
    if (mPhase == P_UP || mPhase == P_DN || mPhase == P_IDLE)
      checkVal("ball_pos", 32'(ball_pos), 32'(mPos));
    if (mPhase == P_OVER)
      checkVal("winner", 32'(winner), 32'(mWinnerRight));
  endtask

  task automatic applyStimulus(input bit rn, input bit hr, input bit hl, input bit se);
    rst_n   = rn;
    hit_r   = hr;
    hit_l   = hl;
    step_en = se;
    @(posedge clk);
    modelStep(rn, hr, hl, se);
    #1;
    checkOutput();
  endtask

  task automatic steps(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; hit_r = 1'b0; hit_l = 1'b0; step_en = 1'b0;

    // Reset and idle
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1);
    checkVal("reset_disp", 32'(disp), 32'h01);
    applyStimulus(1, 0, 0, 1);

    // Simultaneous hits in IDLE: right wins, ball launched upward
    applyStimulus(1, 1, 1, 0);
    checkVal("idle_both_hits", 32'(state_o), 32'(P_UP));

    // Full traverse and miss
    steps(28);
    checkVal("traverse_pos", 32'(ball_pos), 32'd7);
    steps(4);
    checkVal("miss_point_r", 32'(point_r), 32'd1);
    applyStimulus(1, 0, 0, 0);
    checkVal("serve_after_miss", 32'(state_o), 32'(P_SERVE));

    // Early fault at pos 4 with a coincident step
    applyStimulus(1, 1, 0, 0);
    steps(16);
    applyStimulus(1, 0, 1, 1);
    checkVal("early_fault_score", 32'(score_r), 32'd2);
    applyStimulus(1, 0, 0, 1);

    // Wrong server is ignored, then rally with speed-up down to the floor
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    steps(31);
    applyStimulus(1, 0, 1, 1);
    checkVal("return_no_point", 32'(point_r), 32'd0);
    steps(21);
    applyStimulus(1, 1, 0, 0);
    steps(14);
    applyStimulus(1, 0, 1, 0);
    steps(7);
    applyStimulus(1, 1, 0, 0);
    steps(7);
    checkVal("floor_period_pos", 32'(ball_pos), 32'd7);
    steps(1);
    applyStimulus(1, 0, 0, 0);
    checkVal("over_disp", 32'(disp), 32'h0F);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 1, 0);
    checkVal("over_clear", 32'(score_r), 32'd0);

    // Reset mid-rally at pos 5
    applyStimulus(1, 1, 0, 0);
    steps(20);
    applyStimulus(0, 0, 0, 1);
    checkVal("midrally_reset_state", 32'(state_o), 32'(P_IDLE));
    applyStimulus(1, 0, 0, 0);

    // Randomised play
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
